// File: rtl/tt_pkg.sv
// Shared types and defaults for the truth-table scanner.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } tt_state_e;

    localparam int TT_N_IN_DEF   = 3;
    localparam int TT_SETTLE_DEF = 1;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_settle_counter.sv
// Per-vector dwell counter: counts 0..SETTLE while enabled and strobes on the last count.
module tt_settle_counter
    import tt_pkg::*;
#(
    parameter int SETTLE = TT_SETTLE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic sample
);

    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE);

    logic [CW-1:0] cnt;

    assign sample = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= sample ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tt_scanner.sv
// Walks every input vector of a small combinational function, captures its
// truth table and compares it against a reference mask.
module tt_scanner
    import tt_pkg::*;
#(
    parameter int N_IN   = TT_N_IN_DEF,
    parameter int SETTLE = TT_SETTLE_DEF,
    localparam int W     = tt_width(N_IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [W-1:0]    expected,
    output logic [N_IN-1:0] vec_out,
    input  logic            s_in,
    output logic            busy,
    output logic            done,
    output logic [W-1:0]    table_out,
    output logic            match,
    output logic [N_IN:0]   mismatch_cnt,
    output logic [N_IN-1:0] mismatch_idx
);

    tt_state_e       state;
    logic [W-1:0]    expected_q;
    logic            scan_en;
    logic            accept;
    logic            sample;
    logic            last_vec;
    logic            differs;
    logic [N_IN:0]   cnt_next;

    assign scan_en  = (state == SCAN);
    assign accept   = (state == IDLE) && start;
    assign last_vec = (vec_out == N_IN'(W - 1));
    // Case-inequality so an X/Z output is recorded as a difference in simulation.
    assign differs  = (s_in !== expected_q[vec_out]);
    assign cnt_next = mismatch_cnt + {{N_IN{1'b0}}, differs};

    tt_settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .en     (scan_en),
        .sample (sample)
    );

    // vec_out doubles as the scan index; it is forced to 0 outside SCAN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            expected_q   <= '0;
            vec_out      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            table_out    <= '0;
            match        <= 1'b0;
            mismatch_cnt <= '0;
            mismatch_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        expected_q   <= expected;
                        table_out    <= '0;
                        match        <= 1'b0;
                        mismatch_cnt <= '0;
                        mismatch_idx <= '0;
                        vec_out      <= '0;
                        busy         <= 1'b1;
                        state        <= SCAN;
                    end
                end
                SCAN: begin
                    if (sample) begin
                        table_out[vec_out] <= s_in;
                        mismatch_cnt       <= cnt_next;
                        if (differs && (mismatch_cnt == '0)) begin
                            mismatch_idx <= vec_out;
                        end
                        if (last_vec) begin
                            vec_out <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            match   <= (cnt_next == '0);
                            state   <= DONE;
                        end else begin
                            vec_out <= vec_out + N_IN'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_scanner.sv
// Scoreboarded random bench for tt_scanner with SETTLE=1 and SETTLE=0 instances.
module tb_tt_scanner;

    localparam int N = 3;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start1, start0;
    logic [W-1:0] exp1, exp0;
    logic [N-1:0] vec1, vec0;
    logic         s1, s0;
    logic         busy1, busy0, done1, done0, match1, match0;
    logic [W-1:0] tbl1, tbl0;
    logic [N:0]   mcnt1, mcnt0;
    logic [N-1:0] midx1, midx0;
    logic [W-1:0] ft1, ft0;

    assign s1 = ft1[vec1];
    assign s0 = ft0[vec0];

    tt_scanner #(.N_IN(N), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .vec_out(vec1),
        .s_in(s1), .busy(busy1), .done(done1), .table_out(tbl1), .match(match1),
        .mismatch_cnt(mcnt1), .mismatch_idx(midx1)
    );

    tt_scanner #(.N_IN(N), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .expected(exp0), .vec_out(vec0),
        .s_in(s0), .busy(busy0), .done(done0), .table_out(tbl0), .match(match0),
        .mismatch_cnt(mcnt0), .mismatch_idx(midx0)
    );

    typedef struct {
        logic [W-1:0] tbl;
        int           m;
        int           cnt;
        int           idx;
        int           acc;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];
    exp_t e1, e0;
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // The function sweep yields exactly its truth table; compare bit by bit.
    function automatic exp_t model(input logic [W-1:0] ft, input logic [W-1:0] e, input int acc);
        exp_t r;
        r.tbl = ft;
        r.cnt = 0;
        r.idx = 0;
        r.acc = acc;
        for (int i = 0; i < W; i++) begin
            if (ft[i] != e[i]) begin
                if (r.cnt == 0) r.idx = i;
                r.cnt++;
            end
        end
        r.m = (r.cnt == 0) ? 1 : 0;
        return r;
    endfunction

    function automatic logic [W-1:0] golden_tt();
        logic [W-1:0] g;
        for (int i = 0; i < W; i++) begin
            logic a, b, c;
            a = (i >> 2) & 1;
            b = (i >> 1) & 1;
            c = i & 1;
            g[i] = a | (b & ~c);
        end
        return g;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (done1) begin
                if (q1.size() == 0) begin
                    chk("spurious_done1", 1, 0);
                end else begin
                    e1 = q1.pop_front();
                    chk("table1", int'(tbl1), int'(e1.tbl));
                    chk("match1", int'(match1), e1.m);
                    chk("mcnt1", int'(mcnt1), e1.cnt);
                    chk("midx1", int'(midx1), e1.idx);
                    chk("latency1", cyc - e1.acc, W * 2);
                    chk("busy_at_done1", int'(busy1), 0);
                end
            end else if (busy1 && q1.size() > 0) begin
                chk("vec1", int'(vec1), (cyc - q1[0].acc) / 2);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (done0) begin
                if (q0.size() == 0) begin
                    chk("spurious_done0", 1, 0);
                end else begin
                    e0 = q0.pop_front();
                    chk("table0", int'(tbl0), int'(e0.tbl));
                    chk("match0", int'(match0), e0.m);
                    chk("mcnt0", int'(mcnt0), e0.cnt);
                    chk("midx0", int'(midx0), e0.idx);
                    chk("latency0", cyc - e0.acc, W);
                end
            end else if (busy0 && q0.size() > 0) begin
                chk("vec0", int'(vec0), cyc - q0[0].acc);
            end
        end
    end

    task automatic scan1(input logic [W-1:0] ft, input logic [W-1:0] e);
        @(negedge clk);
        ft1    = ft;
        exp1   = e;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        q1.push_back(model(ft, e, cyc));
        start1 = 1'b0;
        exp1   = W'($urandom);
    endtask

    task automatic scan0(input logic [W-1:0] ft, input logic [W-1:0] e);
        @(negedge clk);
        ft0    = ft;
        exp0   = e;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        q0.push_back(model(ft, e, cyc));
        start0 = 1'b0;
        exp0   = W'($urandom);
    endtask

    task automatic drain1();
        int n = 0;
        while (q1.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain1", q1.size(), 0);
        q1.delete();
    endtask

    task automatic drain0();
        int n = 0;
        while (q0.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain0", q0.size(), 0);
        q0.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},  int'(busy1), 0);
        chk({tag, "_done"},  int'(done1), 0);
        chk({tag, "_vec"},   int'(vec1), 0);
        chk({tag, "_table"}, int'(tbl1), 0);
        chk({tag, "_match"}, int'(match1), 0);
        chk({tag, "_mcnt"},  int'(mcnt1), 0);
        chk({tag, "_midx"},  int'(midx1), 0);
    endtask

    initial begin
        logic [W-1:0] g;
        logic [W-1:0] f;
        int n;
        g      = golden_tt();
        ft1    = '0;
        ft0    = '0;
        exp1   = W'($urandom);
        exp0   = W'($urandom);
        start1 = 1'b1;
        start0 = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        chk("reset_busy0", int'(busy0), 0);
        start1 = 1'b0;
        start0 = 1'b0;
        rst_n  = 1'b1;
        repeat (2) @(negedge clk);

        scan1(g, g);
        drain1();
        scan1(g, g | 8'h01);
        drain1();
        scan1(8'hFF, 8'h00);
        drain1();

        for (int k = 0; k < 6; k++) begin
            f = W'($urandom);
            scan1(f, ($urandom_range(0, 2) == 0) ? f : W'($urandom));
            drain1();
        end

        // Starts during SCAN and during the DONE cycle must be dropped.
        scan1(g, g);
        repeat (5) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", int'(done1), 1);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        drain1();
        repeat (20) @(negedge clk);
        chk("ignored_start_busy", int'(busy1), 0);

        // Reset partway through a scan discards it.
        scan1(g, g);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midscan_reset");
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        scan1(g, g);
        drain1();

        scan0(g, g);
        drain0();
        for (int k = 0; k < 4; k++) begin
            f = W'($urandom);
            scan0(f, ($urandom_range(0, 1) == 0) ? f : W'($urandom));
            drain0();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
